// File: rtl/counter_register_if.sv
// Operand/result bundle for counter_register: op and load data in, registered value and status out.
// The master drives op/din/byte_in; the slave (the register) drives dout/valid/wrap.
interface counter_register_if #(
  parameter int BIT_WIDTH = 16
);
  logic [2:0]           op;
  logic [BIT_WIDTH-1:0] din;
  logic [7:0]           byte_in;
  logic [BIT_WIDTH-1:0] dout;
  logic                 valid;
  logic                 wrap;

  modport master (
    output op, din, byte_in,
    input  dout, valid, wrap
  );

  modport slave (
    input  op, din, byte_in,
    output dout, valid, wrap
  );
endinterface

// File: rtl/counter_register.sv
// Multi-purpose counter register (PC / SP / index): hold, load, byte-load, inc, dec, signed add.
// One-cycle latency from op to dout/valid/wrap; no backpressure, an op is applied on every edge.
`ifndef REG_WIDTH
`define REG_WIDTH 16
`endif

module counter_register #(
  parameter int                   BIT_WIDTH    = `REG_WIDTH,
  parameter logic [BIT_WIDTH-1:0] RESET_VECTOR = '0,
  parameter bit                   WRAP         = 1'b1,
  parameter bit                   RESET_VALID  = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  counter_register_if.slave  bus
);

  typedef enum logic [2:0] {
    OP_HOLD    = 3'b000,
    OP_LOAD    = 3'b001,
    OP_INC     = 3'b010,
    OP_DEC     = 3'b011,
    OP_LOAD_LO = 3'b100,
    OP_LOAD_HI = 3'b101,
    OP_ADD     = 3'b110,
    OP_RSVD    = 3'b111
  } op_e;

  localparam bit HAS_HI = (BIT_WIDTH > 8);

  generate
    if (BIT_WIDTH < 8 || BIT_WIDTH > 16) begin : g_bad_width
      $error("counter_register: BIT_WIDTH must be in 8..16");
    end
  endgenerate

  op_e                  w_op;
  logic [BIT_WIDTH-1:0] r_dout;
  logic                 r_valid;
  logic                 r_wrap;
  logic                 r_lo_seen;
  logic                 r_hi_seen;

  logic [BIT_WIDTH-1:0] w_dout_nxt;
  logic                 w_valid_nxt;
  logic                 w_wrap_nxt;
  logic                 w_lo_nxt;
  logic                 w_hi_nxt;

  logic [BIT_WIDTH-1:0] w_load_lo;
  logic [BIT_WIDTH-1:0] w_load_hi;
  logic [BIT_WIDTH+1:0] w_delta;
  logic [BIT_WIDTH+1:0] w_sum;
  logic                 w_ovf;
  logic                 w_unf;
  logic [BIT_WIDTH-1:0] w_arith;

  assign w_op = op_e'(bus.op);

  generate
    if (BIT_WIDTH > 8) begin : g_wide
      assign w_load_lo = {r_dout[BIT_WIDTH-1:8], bus.byte_in};
      assign w_load_hi = {bus.byte_in[BIT_WIDTH-9:0], r_dout[7:0]};
    end else begin : g_narrow
      assign w_load_lo = bus.byte_in;
      assign w_load_hi = r_dout;
    end
  endgenerate

  // INC, DEC and ADD share one adder: the operand is +1, -1 or sign-extended byte_in.
  always_comb begin
    w_delta = {{(BIT_WIDTH-6){bus.byte_in[7]}}, bus.byte_in};
    case (w_op)
      OP_INC:  w_delta = {{(BIT_WIDTH+1){1'b0}}, 1'b1};
      OP_DEC:  w_delta = '1;
      default: w_delta = {{(BIT_WIDTH-6){bus.byte_in[7]}}, bus.byte_in};
    endcase
  end

  // Two guard bits: top bit set means the result went negative, next bit means it passed all-ones.
  assign w_sum   = {2'b00, r_dout} + w_delta;
  assign w_unf   = w_sum[BIT_WIDTH+1];
  assign w_ovf   = ~w_sum[BIT_WIDTH+1] & w_sum[BIT_WIDTH];
  assign w_arith = (WRAP || !(w_ovf || w_unf)) ? w_sum[BIT_WIDTH-1:0] :
                   (w_ovf ? {BIT_WIDTH{1'b1}} : {BIT_WIDTH{1'b0}});

  always_comb begin
    w_dout_nxt  = r_dout;
    w_valid_nxt = r_valid;
    w_wrap_nxt  = 1'b0;
    w_lo_nxt    = r_lo_seen;
    w_hi_nxt    = r_hi_seen;
    case (w_op)
      OP_LOAD: begin
        w_dout_nxt  = bus.din;
        w_valid_nxt = 1'b1;
      end
      OP_INC, OP_DEC, OP_ADD: begin
        w_dout_nxt = w_arith;
        w_wrap_nxt = w_ovf | w_unf;
      end
      OP_LOAD_LO: begin
        w_dout_nxt = w_load_lo;
        w_lo_nxt   = 1'b1;
      end
      OP_LOAD_HI: begin
        if (HAS_HI) begin
          w_dout_nxt = w_load_hi;
          w_hi_nxt   = 1'b1;
        end
      end
      default: begin
      end
    endcase
    // Both halves seen (in either order) makes the value usable; narrow registers need only the low byte.
    if (w_lo_nxt && (w_hi_nxt || !HAS_HI)) begin
      w_valid_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dout    <= RESET_VECTOR;
      r_valid   <= RESET_VALID;
      r_wrap    <= 1'b0;
      r_lo_seen <= 1'b0;
      r_hi_seen <= 1'b0;
    end else begin
      r_dout    <= w_dout_nxt;
      r_valid   <= w_valid_nxt;
      r_wrap    <= w_wrap_nxt;
      r_lo_seen <= w_lo_nxt;
      r_hi_seen <= w_hi_nxt;
    end
  end

  assign bus.dout  = r_dout;
  assign bus.valid = r_valid;
  assign bus.wrap  = r_wrap;

endmodule

// File: tb/tb_counter_register.sv
// Scoreboard bench: four counter_register configurations driven in lockstep, checked against an integer model.
module tb_counter_register;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  counter_register_if #(.BIT_WIDTH(16)) b0();
  counter_register_if #(.BIT_WIDTH(8))  b1();
  counter_register_if #(.BIT_WIDTH(8))  b2();
  counter_register_if #(.BIT_WIDTH(16)) b3();

  counter_register #(.BIT_WIDTH(16), .RESET_VECTOR(16'hFFFC), .WRAP(1'b1), .RESET_VALID(1'b0))
    u0 (.clk(clk), .reset(reset), .bus(b0));
  counter_register #(.BIT_WIDTH(8), .RESET_VECTOR(8'hFD), .WRAP(1'b1), .RESET_VALID(1'b1))
    u1 (.clk(clk), .reset(reset), .bus(b1));
  counter_register #(.BIT_WIDTH(8), .RESET_VECTOR(8'h00), .WRAP(1'b0), .RESET_VALID(1'b0))
    u2 (.clk(clk), .reset(reset), .bus(b2));
  counter_register #(.BIT_WIDTH(16), .RESET_VECTOR(16'h0000), .WRAP(1'b0), .RESET_VALID(1'b0))
    u3 (.clk(clk), .reset(reset), .bus(b3));

  int total = 0;
  int bad   = 0;

  // Configuration of each instance, and the model's view of it.
  int cw[4]  = '{16, 8, 8, 16};
  int crv[4] = '{'hFFFC, 'hFD, 0, 0};
  bit cwr[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
  bit cvr[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  int md[4];
  bit mv[4], mw[4], mlo[4], mhi[4];

  typedef struct packed {
    logic [15:0] d0;
    logic [7:0]  d1;
    logic [7:0]  d2;
    logic [15:0] d3;
    logic [3:0]  v;
    logic [3:0]  w;
  } exp_t;
  exp_t sbq[$];
  exp_t e;

  function automatic void chk(string name, logic [15:0] act, logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 4; k++) begin
      md[k] = crv[k]; mv[k] = cvr[k]; mw[k] = 1'b0; mlo[k] = 1'b0; mhi[k] = 1'b0;
    end
  endfunction

  function automatic void model_step(int k, logic [2:0] op, logic [15:0] din, logic [7:0] b);
    int maxv = (1 << cw[k]) - 1;
    int r;
    int off;
    mw[k] = 1'b0;
    case (op)
      3'd1: begin md[k] = int'(din) & maxv; mv[k] = 1'b1; end
      3'd2, 3'd3, 3'd6: begin
        off = (op == 3'd2) ? 1 : (op == 3'd3) ? -1 : int'($signed(b));
        r = md[k] + off;
        if (r > maxv) begin
          md[k] = cwr[k] ? r - (maxv + 1) : maxv; mw[k] = 1'b1;
        end else if (r < 0) begin
          md[k] = cwr[k] ? r + (maxv + 1) : 0;    mw[k] = 1'b1;
        end else begin
          md[k] = r;
        end
      end
      3'd4: begin
        md[k] = (md[k] & ~255) | int'(b);
        mlo[k] = 1'b1;
        if (mhi[k] || cw[k] == 8) mv[k] = 1'b1;
      end
      3'd5: begin
        if (cw[k] > 8) begin
          md[k] = (md[k] & 255) | ((int'(b) << 8) & maxv);
          mhi[k] = 1'b1;
          if (mlo[k]) mv[k] = 1'b1;
        end
      end
      default: begin end
    endcase
  endfunction

  task automatic drive(input logic [2:0] op, input logic [15:0] din, input logic [7:0] b);
    exp_t x;
    b0.op = op; b0.din = din;      b0.byte_in = b;
    b1.op = op; b1.din = din[7:0]; b1.byte_in = b;
    b2.op = op; b2.din = din[7:0]; b2.byte_in = b;
    b3.op = op; b3.din = din;      b3.byte_in = b;
    for (int k = 0; k < 4; k++) model_step(k, op, din, b);
    x.d0 = md[0][15:0]; x.d1 = md[1][7:0]; x.d2 = md[2][7:0]; x.d3 = md[3][15:0];
    x.v = {mv[3], mv[2], mv[1], mv[0]};
    x.w = {mw[3], mw[2], mw[1], mw[0]};
    sbq.push_back(x);
  endtask

  task automatic issue(input logic [2:0] op, input logic [15:0] din, input logic [7:0] b);
    @(negedge clk);
    drive(op, din, b);
  endtask

  task automatic release_rst();
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    drive(3'b000, 16'(($urandom)), 8'($urandom));
  endtask

  // Assert reset between edges while an op stream is running; outputs must change before any edge.
  task automatic mid_reset();
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("arst_dout0", b0.dout, 16'hFFFC);
    chk("arst_valid0", {15'b0, b0.valid}, 16'd0);
    chk("arst_wrap0", {15'b0, b0.wrap}, 16'd0);
    chk("arst_dout1", {8'b0, b1.dout}, 16'h00FD);
    chk("arst_valid1", {15'b0, b1.valid}, 16'd1);
    chk("arst_dout3", b3.dout, 16'h0000);
    @(negedge clk);
    release_rst();
  endtask

  task automatic peek(input int k, input string n, input logic [15:0] d, input logic v, input logic w);
    logic [15:0] ad;
    logic av, aw;
    @(posedge clk);
    #2;
    case (k)
      0:       begin ad = b0.dout;          av = b0.valid; aw = b0.wrap; end
      1:       begin ad = {8'b0, b1.dout};  av = b1.valid; aw = b1.wrap; end
      2:       begin ad = {8'b0, b2.dout};  av = b2.valid; aw = b2.wrap; end
      default: begin ad = b3.dout;          av = b3.valid; aw = b3.wrap; end
    endcase
    chk({n, "_dout"}, ad, d);
    chk({n, "_valid"}, {15'b0, av}, {15'b0, v});
    chk({n, "_wrap"}, {15'b0, aw}, {15'b0, w});
  endtask

  // Monitor: every edge that follows issued stimulus owes exactly one scoreboard entry.
  always @(posedge clk) begin
    #1;
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      chk("sb_dout0", b0.dout, e.d0);
      chk("sb_dout1", {8'b0, b1.dout}, {8'b0, e.d1});
      chk("sb_dout2", {8'b0, b2.dout}, {8'b0, e.d2});
      chk("sb_dout3", b3.dout, e.d3);
      chk("sb_valid", {12'b0, b3.valid, b2.valid, b1.valid, b0.valid}, {12'b0, e.v});
      chk("sb_wrap",  {12'b0, b3.wrap,  b2.wrap,  b1.wrap,  b0.wrap},  {12'b0, e.w});
    end
  end

  initial begin
    reset = 1'b1;
    {b0.op, b1.op, b2.op, b3.op} = '0;
    {b0.din, b1.din, b2.din, b3.din} = '0;
    {b0.byte_in, b1.byte_in, b2.byte_in, b3.byte_in} = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_dout0", b0.dout, 16'hFFFC);
    chk("rst_valid0", {15'b0, b0.valid}, 16'd0);
    chk("rst_wrap0", {15'b0, b0.wrap}, 16'd0);
    chk("rst_dout1", {8'b0, b1.dout}, 16'h00FD);
    chk("rst_valid1", {15'b0, b1.valid}, 16'd1);
    release_rst();

    // Split load, low byte first.
    issue(3'b100, 16'($urandom), 8'h34); peek(3, "lo_first", 16'h0034, 1'b0, 1'b0);
    issue(3'b000, 16'($urandom), 8'($urandom));
    issue(3'b101, 16'($urandom), 8'h12); peek(3, "hi_second", 16'h1234, 1'b1, 1'b0);

    // Reset in the middle of an INC stream, then resume.
    repeat (3) issue(3'b010, 16'($urandom), 8'($urandom));
    mid_reset();
    issue(3'b010, 16'($urandom), 8'($urandom)); peek(0, "rst_inc", 16'hFFFD, 1'b0, 1'b0);

    // Split load, high byte first (u3 holds 0001 after the INC).
    issue(3'b101, 16'($urandom), 8'h12); peek(3, "hi_first", 16'h1201, 1'b0, 1'b0);
    issue(3'b000, 16'($urandom), 8'($urandom));
    issue(3'b100, 16'($urandom), 8'h34); peek(3, "lo_second", 16'h1234, 1'b1, 1'b0);

    // Stack pointer walk down through zero.
    issue(3'b000, 16'($urandom), 8'($urandom));
    mid_reset();
    issue(3'b011, 16'($urandom), 8'($urandom)); peek(1, "sp_dec1", 16'h00FC, 1'b1, 1'b0);
    issue(3'b011, 16'($urandom), 8'($urandom)); peek(1, "sp_dec2", 16'h00FB, 1'b1, 1'b0);
    issue(3'b011, 16'($urandom), 8'($urandom)); peek(1, "sp_dec3", 16'h00FA, 1'b1, 1'b0);
    issue(3'b001, 16'h0001, 8'($urandom));
    issue(3'b011, 16'($urandom), 8'($urandom)); peek(1, "sp_zero", 16'h0000, 1'b1, 1'b0);
    issue(3'b011, 16'($urandom), 8'($urandom)); peek(1, "sp_under", 16'h00FF, 1'b1, 1'b1);
    issue(3'b000, 16'($urandom), 8'($urandom)); peek(1, "sp_pulse", 16'h00FF, 1'b1, 1'b0);
    issue(3'b010, 16'($urandom), 8'($urandom)); peek(1, "sp_over", 16'h0000, 1'b1, 1'b1);

    // Saturating 8-bit counter.
    issue(3'b001, 16'h00FE, 8'($urandom));
    issue(3'b010, 16'($urandom), 8'($urandom)); peek(2, "sat_inc1", 16'h00FF, 1'b1, 1'b0);
    issue(3'b010, 16'($urandom), 8'($urandom)); peek(2, "sat_inc2", 16'h00FF, 1'b1, 1'b1);
    issue(3'b010, 16'($urandom), 8'($urandom)); peek(2, "sat_inc3", 16'h00FF, 1'b1, 1'b1);
    issue(3'b001, 16'h0000, 8'($urandom));
    issue(3'b011, 16'($urandom), 8'($urandom)); peek(2, "sat_dec0", 16'h0000, 1'b1, 1'b1);

    // Branch offsets on the 16-bit PC.
    issue(3'b001, 16'h80F0, 8'($urandom));
    issue(3'b110, 16'($urandom), 8'h20); peek(0, "add_fwd", 16'h8110, 1'b1, 1'b0);
    issue(3'b110, 16'($urandom), 8'hF0); peek(0, "add_back", 16'h8100, 1'b1, 1'b0);
    issue(3'b001, 16'h0005, 8'($urandom));
    issue(3'b110, 16'($urandom), 8'h80); peek(0, "add_under", 16'hFF85, 1'b1, 1'b1);

    // Reserved op and HOLD leave everything alone.
    issue(3'b001, 16'hABCD, 8'($urandom));
    for (int i = 0; i < 4; i++) begin
      issue(($urandom_range(0, 1) != 0) ? 3'b111 : 3'b000, 16'($urandom), 8'($urandom));
      peek(0, "hold", 16'hABCD, 1'b1, 1'b0);
    end

    // Random traffic with occasional asynchronous resets.
    for (int i = 0; i < 400; i++) begin
      if (i % 100 == 99) mid_reset();
      else issue(3'($urandom), 16'($urandom), 8'($urandom));
    end
    issue(3'b000, 16'($urandom), 8'($urandom));
    repeat (2) @(posedge clk);
    #3;
    chk("sb_drained", 16'(sbq.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
